// File: rtl/prog_divider_chain.sv
// Programmable clock-enable divider: one-cycle tick every Neff enabled cycles, optional
// square wave, and a wrapping/saturating tick counter. Optional PWM: PROG_DIVIDER_PWM_EN.
module prog_divider_chain #(
    parameter int DIV_W    = 8,
    parameter int EVT_W    = 7,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             clr_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             mode_i,
`ifdef PROG_DIVIDER_PWM_EN
    input  logic [DIV_W-1:0] duty_i,
    output logic             pwm_o,
`endif
    output logic             tick_o,
    output logic             wave_o,
    output logic [EVT_W-1:0] evt_cnt_o,
    output logic             evt_wrap_o
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] neff_m1;
    logic             toggle;
    logic             terminal;
    logic             evt_at_max;

    // Divisors 0 and 1 both collapse to a terminal count of 0, so no underflow.
    assign neff_m1    = (div_q < DIV_W'(2)) ? '0 : div_q - DIV_W'(1);
    assign terminal   = ena & ~clr_i & (cnt >= neff_m1);
    assign evt_at_max = (evt_cnt_o == {EVT_W{1'b1}});
    assign wave_o     = mode_i ? toggle : tick_o;

`ifdef PROG_DIVIDER_PWM_EN
    assign pwm_o = ena & (cnt < duty_i);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            div_q      <= '0;
            tick_o     <= 1'b0;
            toggle     <= 1'b0;
            evt_cnt_o  <= '0;
            evt_wrap_o <= 1'b0;
        end else if (clr_i) begin
            cnt        <= '0;
            div_q      <= div_i;
            tick_o     <= 1'b0;
            toggle     <= 1'b0;
            evt_cnt_o  <= '0;
            evt_wrap_o <= 1'b0;
        end else begin
            // A new divisor is only picked up between periods or while idle.
            if (!ena || terminal || div_q == '0) begin
                div_q <= div_i;
            end

            if (ena) begin
                if (terminal) begin
                    cnt    <= '0;
                    tick_o <= 1'b1;
                    toggle <= ~toggle;
                end else begin
                    cnt    <= cnt + DIV_W'(1);
                    tick_o <= 1'b0;
                end
            end else begin
                tick_o <= 1'b0;
            end

            if (SATURATE != 0) begin
                // Sticky flag: set on the first tick that finds the counter already full.
                if (terminal) begin
                    if (evt_at_max) begin
                        evt_wrap_o <= 1'b1;
                    end else begin
                        evt_cnt_o <= evt_cnt_o + EVT_W'(1);
                    end
                end
            end else begin
                evt_wrap_o <= terminal & evt_at_max;
                if (terminal) begin
                    evt_cnt_o <= evt_cnt_o + EVT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_divider_chain.sv
// Self-checking bench for prog_divider_chain: a wrapping and a saturating instance
// share stimulus; table-driven basic division plus directed corner sequences.
module tb_prog_divider_chain;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       clr_i;
    logic [7:0] div_i;
    logic       mode_i;
    logic       tick0, wave0, wrap0;
    logic       tick1, wave1, wrap1;
    logic [6:0] evt0, evt1;
`ifdef PROG_DIVIDER_PWM_EN
    logic [7:0] duty_i;
    logic       pwm0, pwm1;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       ena;
        logic       clr;
        logic [7:0] div;
        logic       mode;
        logic       exp_tick;
        logic       exp_wave;
    } vec_t;

    vec_t       vecs[21];
    logic [6:0] exp_q[$];

    prog_divider_chain #(.DIV_W(8), .EVT_W(7), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clr_i(clr_i), .div_i(div_i), .mode_i(mode_i),
`ifdef PROG_DIVIDER_PWM_EN
        .duty_i(duty_i), .pwm_o(pwm0),
`endif
        .tick_o(tick0), .wave_o(wave0), .evt_cnt_o(evt0), .evt_wrap_o(wrap0)
    );

    prog_divider_chain #(.DIV_W(8), .EVT_W(7), .SATURATE(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clr_i(clr_i), .div_i(div_i), .mode_i(mode_i),
`ifdef PROG_DIVIDER_PWM_EN
        .duty_i(duty_i), .pwm_o(pwm1),
`endif
        .tick_o(tick1), .wave_o(wave1), .evt_cnt_o(evt1), .evt_wrap_o(wrap1)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic c, input logic [7:0] d, input logic m);
        ena    = e;
        clr_i  = c;
        div_i  = d;
        mode_i = m;
    endtask

    initial begin
        int pwm_high;
        pwm_high = 0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 8'd0, 1'b0);
`ifdef PROG_DIVIDER_PWM_EN
        duty_i = 8'd0;
`endif
        #12;
        rst_n = 1'b1;
        #1;
        check("reset_tick", {31'd0, tick0}, 0);
        check("reset_wave", {31'd0, wave0}, 0);
        check("reset_evt", {25'd0, evt0}, 0);
        check("reset_wrap", {31'd0, wrap0}, 0);

        // Divide by 4: row 0 is a clear that loads the divisor, then 20 enabled edges.
        vecs[0] = '{ena: 1'b1, clr: 1'b1, div: 8'd4, mode: 1'b0, exp_tick: 1'b0, exp_wave: 1'b0};
        exp_q.push_back(7'd0);
        for (int k = 1; k <= 20; k++) begin
            vecs[k] = '{ena: 1'b1, clr: 1'b0, div: 8'd4, mode: 1'b0,
                        exp_tick: (k % 4 == 0), exp_wave: (k % 4 == 0)};
            exp_q.push_back(7'(k / 4));
        end
        for (int i = 0; i < 21; i++) begin
            logic [6:0] exp_evt;
            drive(vecs[i].ena, vecs[i].clr, vecs[i].div, vecs[i].mode);
            step();
            exp_evt = exp_q.pop_front();
            check($sformatf("div4_tick[%0d]", i), {31'd0, tick0}, {31'd0, vecs[i].exp_tick});
            check($sformatf("div4_wave[%0d]", i), {31'd0, wave0}, {31'd0, vecs[i].exp_wave});
            check($sformatf("div4_evt[%0d]", i), {25'd0, evt0}, {25'd0, exp_evt});
        end

        // Divide by 3, square wave: toggles on edges 3, 6, 9...
        drive(1'b1, 1'b1, 8'd3, 1'b1);
        step();
        check("sq_after_clr", {31'd0, wave0}, 0);
        clr_i = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            check($sformatf("sq_wave[%0d]", k), {31'd0, wave0}, 32'((k / 3) % 2));
        end
        mode_i = 1'b0;
        #1;
        check("mode_switch_now", {31'd0, wave0}, 0);
        step();
        check("mode0_e11", {31'd0, wave0}, 0);
        step();
        check("mode0_e12", {31'd0, wave0}, 1);
        mode_i = 1'b1;
        #1;
        check("toggle_retained", {31'd0, wave0}, 0);

        // Divisor 0 then 1: continuous tick; dropping ena stops it and freezes counting.
        drive(1'b1, 1'b1, 8'd0, 1'b0);
        step();
        clr_i = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("div0_tick[%0d]", k), {31'd0, tick0}, 1);
        end
        check("div0_evt", {25'd0, evt0}, 3);
        div_i = 8'd1;
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("div1_tick[%0d]", k), {31'd0, tick0}, 1);
        end
        check("div1_evt", {25'd0, evt0}, 6);
        ena = 1'b0;
        step();
        check("ena_low_tick", {31'd0, tick0}, 0);
        step();
        check("ena_low_evt", {25'd0, evt0}, 6);

        // Event counter wrap versus saturation.
        drive(1'b1, 1'b1, 8'd1, 1'b0);
        step();
        clr_i = 1'b0;
        for (int k = 0; k < 127; k++) step();
        check("pre_wrap_evt", {25'd0, evt0}, 127);
        check("pre_wrap_flag", {31'd0, wrap0}, 0);
        check("pre_sat_evt", {25'd0, evt1}, 127);
        check("pre_sat_flag", {31'd0, wrap1}, 0);
        step();
        check("wrap_evt", {25'd0, evt0}, 0);
        check("wrap_flag", {31'd0, wrap0}, 1);
        check("sat_evt", {25'd0, evt1}, 127);
        check("sat_flag", {31'd0, wrap1}, 1);
        step();
        check("post_wrap_evt", {25'd0, evt0}, 1);
        check("post_wrap_flag", {31'd0, wrap0}, 0);
        check("sat_hold_evt", {25'd0, evt1}, 127);
        ena = 1'b0;
        step();
        step();
        check("sat_sticky", {31'd0, wrap1}, 1);
        clr_i = 1'b1;
        step();
        check("sat_clr_evt", {25'd0, evt1}, 0);
        check("sat_clr_flag", {31'd0, wrap1}, 0);

        // Divisor shrunk 8 -> 2 mid-period: current period still ends at edge 8.
        drive(1'b1, 1'b1, 8'd8, 1'b0);
        step();
        clr_i = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 4) div_i = 8'd2;
            step();
            check($sformatf("shrink_tick[%0d]", k), {31'd0, tick0},
                  {31'd0, (k == 8 || k == 10 || k == 12)});
        end
        check("shrink_evt", {25'd0, evt0}, 3);
        mode_i = 1'b1;
        #1;
        check("pre_rst_wave", {31'd0, wave0}, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_tick", {31'd0, tick0}, 0);
        check("async_rst_wave", {31'd0, wave0}, 0);
        check("async_rst_evt", {25'd0, evt0}, 0);
        #2;
        rst_n = 1'b1;

`ifdef PROG_DIVIDER_PWM_EN
        drive(1'b1, 1'b1, 8'd8, 1'b0);
        duty_i = 8'd3;
        step();
        clr_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (pwm0) pwm_high++;
        end
        check("pwm_duty3", pwm_high, 3);
        duty_i   = 8'd9;
        pwm_high = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (pwm0) pwm_high++;
        end
        check("pwm_duty9", pwm_high, 8);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_divider_chain.md
Name: prog_divider_chain

Overview:
- Parametrised programmable clock-enable divider with a cascaded event counter.
- Generates a one-cycle tick every N enabled clk cycles, plus an optional 50%-duty square wave of period 2N.
- Counts ticks in a second-stage counter that either wraps or saturates.
- Fully synchronous to clk (no derived-clock flops); sits between the input switches and the bidirectional outputs as the design's timebase generator.

Parameters:
- DIV_W, 8, width of divisor input and stage-1 counter.
- EVT_W, 7, width of stage-2 event counter.
- SATURATE, 0, 0 = event counter wraps to 0; 1 = event counter holds at max.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low; all flops cleared.
- ena  in  1  count enable; low freezes stage-1 counter.
- clr_i  in  1  synchronous clear, priority over ena.
- div_i  in  DIV_W  divisor N (0 and 1 both mean divide-by-1).
- mode_i  in  1  0 = wave_o follows tick_o; 1 = wave_o is toggle square wave.
- tick_o  out  1  registered one-cycle tick.
- wave_o  out  1  tick or square wave per mode_i.
- evt_cnt_o  out  EVT_W  number of ticks since reset/clear.
- evt_wrap_o  out  1  wrap pulse (SATURATE=0) or sticky saturation flag (SATURATE=1).

Behaviour:
- Reset (rst_n low, async): cnt=0, div_q=0, tick_o=0, toggle=0, evt_cnt_o=0, evt_wrap_o=0.
- Effective period Neff = (div_q < 2) ? 1 : div_q.
- div_q load conditions: reloads from div_i on the terminal edge, on any edge with ena=0, on clr_i, and when div_q==0.
  - A mid-period div_i change takes effect only at the next terminal count.
- Stage 1, when ena=1 and clr_i=0:
  - If cnt >= Neff-1: cnt<=0, tick_o<=1 (terminal edge).
  - Else: cnt<=cnt+1, tick_o<=0.
  - The >= compare covers a divisor shrunk below cnt while ena is low.
- Stage 1, when ena=0: cnt holds, tick_o<=0.
- Tick timing: tick_o is high for exactly one cycle after every Neff enabled edges; the first tick follows the Neff-th enabled edge after reset or clear.
- Square wave: toggle flips on every terminal edge. wave_o = mode_i ? toggle : tick_o.
  - In mode 1, period is 2*Neff enabled cycles.
  - mode_i switches the mux immediately; toggle state is retained across mode changes.
- Stage 2 advances on the same edge as the terminal edge:
  - SATURATE=0: evt_cnt increments, wrapping from 2^EVT_W-1 to 0. evt_wrap_o<=1 for that one cycle only, 0 otherwise.
  - SATURATE=1: evt_cnt increments until 2^EVT_W-1 and then holds. evt_wrap_o<=1 on the first terminal edge at max and stays 1 until clr_i or reset.
- clr_i=1 (sync, overrides ena): cnt, tick_o, toggle, evt_cnt, evt_wrap_o all go to 0; div_q<=div_i.
- Arithmetic: all counters are unsigned. div_i is compared at DIV_W bits; no subtraction underflow, because div values 0/1 are mapped to Neff=1 before compare.
- Divide-by-1: tick_o is high continuously while ena=1, and evt_cnt increments every cycle.

Optional Feature:
- Macro PROG_DIVIDER_PWM_EN.
- When defined: adds input duty_i [DIV_W] and output pwm_o [1].
  - pwm_o = ena & (cnt < duty_i), combinational from registered cnt.
  - duty_i=0 gives constant 0; duty_i >= Neff gives constant 1 while ena=1.
- When undefined: duty_i and pwm_o do not exist; no compare logic is instantiated.

Test Plan:
- Reset, div_i=4, mode_i=0, ena=1 for 20 cycles -> tick_o high after enabled edges 4, 8, 12, 16, 20; evt_cnt_o=5.
- div_i=3, mode_i=1, ena=1 -> wave_o toggles every 3 cycles (period 6); switch mode_i to 0 mid-run -> wave_o equals tick_o on the next cycle.
- div_i=0, then div_i=1 -> tick_o continuously high with ena=1; drop ena -> tick_o=0 next cycle and cnt frozen.
- SATURATE=0, EVT_W=7, div_i=1, 128 ticks -> evt_cnt_o returns to 0, evt_wrap_o high for one cycle. SATURATE=1 -> evt_cnt_o holds at 127 and evt_wrap_o stays high until clr_i.
- div_i changed 8->2 at cnt=3 with ena=1 -> current period completes at 8, next period is 2. Assert rst_n low mid-period -> all outputs 0 immediately, without waiting for a clock edge.
- PROG_DIVIDER_PWM_EN, div_i=8, duty_i=3 -> pwm_o high for 3 of every 8 cycles; duty_i=9 -> pwm_o constant 1.
